fb_write_scheduler: RTL and testbench

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

---
 rtl/fb_write_scheduler.sv | 110 +++++++++++
 tb/tb_fb_write_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: round-robin arbitration between two pixel
// writers, with a vsync-triggered full-frame clear engine that owns the port.
module fb_write_scheduler #(
  parameter int FB_PIXELS = 307200,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              clear_en,
  input  logic [DATA_W-1:0] clear_color,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              clear_overrun
);

  typedef enum logic {ARB, CLEAR} state_t;

  // FB_PIXELS must fit in the ADDR_W-wide clear counter.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   counter;
  logic [DATA_W-1:0]   color_reg;
  logic                last_grant;
  logic                vsync_d;
  logic                vsync_fall;
  logic                arb_active;
  logic                grant0;
  logic                grant1;

  assign vsync_fall = vsync_d & ~vsync;
  assign arb_active = (state == ARB) & ~reset;

  // last_grant=1 means requester 1 was served last, so requester 0 wins a tie.
  assign grant0 = arb_active & req0_valid & (~req1_valid | last_grant);
  assign grant1 = arb_active & req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign clear_busy = (state == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ARB;
      counter       <= '0;
      color_reg     <= '0;
      last_grant    <= 1'b1;
      vsync_d       <= 1'b1;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      clear_done    <= 1'b0;
      clear_overrun <= 1'b0;
    end else begin
      vsync_d       <= vsync;
      wr_en         <= 1'b0;
      clear_done    <= 1'b0;
      clear_overrun <= 1'b0;
      case (state)
        ARB: begin
          if (grant0) begin
            wr_en      <= 1'b1;
            wr_addr    <= req0_addr;
            wr_data    <= req0_data;
            last_grant <= 1'b0;
          end else if (grant1) begin
            wr_en      <= 1'b1;
            wr_addr    <= req1_addr;
            wr_data    <= req1_data;
            last_grant <= 1'b1;
          end
          if (vsync_fall && clear_en) begin
            state     <= CLEAR;
            counter   <= '0;
            color_reg <= clear_color;
          end
        end
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= counter;
          wr_data <= color_reg;
          // A vsync during a clear is only reported; the clear runs to completion.
          if (vsync_fall) clear_overrun <= 1'b1;
          if (counter == LAST_ADDR) begin
            state      <= ARB;
            counter    <= '0;
            clear_done <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler with a 16-pixel framebuffer.
module tb_fb_write_scheduler;

  localparam int NPIX = 16;
  localparam int AW   = 8;
  localparam int DW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b1;
  logic          clear_en = 1'b0;
  logic [DW-1:0] clear_color = '0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, wr_en, clear_busy, clear_done, clear_overrun;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int failures = 0;

  fb_write_scheduler #(.FB_PIXELS(NPIX), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .clear_en(clear_en), .clear_color(clear_color),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_busy(clear_busy), .clear_done(clear_done), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b1; clear_en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, clear_busy, clear_done, clear_overrun, req0_ready, req1_ready} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: en=%0b addr=%0h data=%0h busy=%0b done=%0b ovr=%0b rdy=%0b%0b, all should be 0",
               wr_en, wr_addr, wr_data, clear_busy, clear_done, clear_overrun, req0_ready, req1_ready);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 8'd5; req0_data = 4'd3;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_ready: got %0b%0b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 8'd5 || wr_data !== 4'd3) begin
      failures++;
      $display("[TB] FAIL single_write: got en=%0b addr=%0d data=%0d want 1/5/3", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 8'd5 || wr_data !== 4'd3) begin
      failures++;
      $display("[TB] FAIL single_hold: got en=%0b addr=%0d data=%0d want 0/5/3", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_round_robin_after_reset();
    logic [AW-1:0] exp_addr;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 8'h10; req0_data = 4'h1;
    req1_valid = 1'b1; req1_addr = 8'h20; req1_data = 4'h2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        failures++;
        $display("[TB] FAIL rr_grant[%0d]: got %0b%0b want %0b%0b", i, req0_ready, req1_ready,
                 (i % 2 == 0), (i % 2 == 1));
      end
      exp_addr = (i % 2 == 0) ? req0_addr : req1_addr;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== exp_addr) begin
        failures++;
        $display("[TB] FAIL rr_write[%0d]: got en=%0b addr=%0h want 1/%0h", i, wr_en, wr_addr, exp_addr);
      end
      if (i % 2 == 0) req0_addr = req0_addr + 8'd1;
      else            req1_addr = req1_addr + 8'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Random two-requester traffic checked against a round-robin reference.
  task automatic test_random_arbitration();
    logic          model_last;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          e0, e1, acc0, acc1;
    do_reset();
    model_last = 1'b1; exp_en = 1'b0; exp_addr = '0; exp_data = '0;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== exp_en || wr_addr !== exp_addr || wr_data !== exp_data) begin
        failures++;
        $display("[TB] FAIL rand_write[%0d]: got en=%0b addr=%0h data=%0h want %0b/%0h/%0h",
                 n, wr_en, wr_addr, wr_data, exp_en, exp_addr, exp_data);
      end
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_addr = 8'($urandom); req0_data = 4'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_addr = 8'($urandom); req1_data = 4'($urandom);
      end
      #1;
      e0 = req0_valid && (!req1_valid || model_last);
      e1 = req1_valid && (!req0_valid || !model_last);
      checks++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        failures++;
        $display("[TB] FAIL rand_grant[%0d]: got %0b%0b want %0b%0b", n, req0_ready, req1_ready, e0, e1);
      end
      acc0 = e0; acc1 = e1;
      if (e0) begin
        exp_en = 1'b1; exp_addr = req0_addr; exp_data = req0_data; model_last = 1'b0;
      end else if (e1) begin
        exp_en = 1'b1; exp_addr = req1_addr; exp_data = req1_data; model_last = 1'b1;
      end else begin
        exp_en = 1'b0;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Full clear, optionally with a second vsync arriving at clear write 8.
  task automatic test_clear_frame(input bit with_overrun);
    int overruns;
    do_reset();
    clear_en = 1'b1; clear_color = 4'd7;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1; clear_color = 4'd2;
    req0_valid = 1'b1; req0_addr = 8'($urandom);
    req1_valid = 1'b1; req1_addr = 8'($urandom);
    #1;
    checks++;
    if (clear_busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || wr_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_start: got busy=%0b rdy=%0b%0b en=%0b want 1/00/0",
               clear_busy, req0_ready, req1_ready, wr_en);
    end
    overruns = 0;
    for (int w = 0; w < NPIX; w++) begin
      @(negedge clk);
      if (clear_overrun === 1'b1) overruns++;
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(w) || wr_data !== 4'd7 || clear_done !== (w == NPIX - 1) ||
          clear_busy !== (w != NPIX - 1) || clear_overrun !== (with_overrun && w == 9)) begin
        failures++;
        $display("[TB] FAIL clear_write[%0d]: got en=%0b addr=%0d data=%0d done=%0b busy=%0b ovr=%0b want 1/%0d/7/%0b/%0b/%0b",
                 w, wr_en, wr_addr, wr_data, clear_done, clear_busy, clear_overrun, w,
                 (w == NPIX - 1), (w != NPIX - 1), (with_overrun && w == 9));
      end
      if (with_overrun && w == 8) vsync = 1'b0;
      if (w == 9) vsync = 1'b1;
      if (w == NPIX - 1) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end else begin
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL clear_ready[%0d]: got %0b%0b want 00", w, req0_ready, req1_ready);
        end
      end
    end
    @(negedge clk);
    if (clear_overrun === 1'b1) overruns++;
    checks++;
    if (wr_en !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0 || overruns != int'(with_overrun)) begin
      failures++;
      $display("[TB] FAIL clear_end: got en=%0b busy=%0b done=%0b overruns=%0d want 0/0/0/%0d",
               wr_en, clear_busy, clear_done, overruns, int'(with_overrun));
    end
    clear_en = 1'b0;
  endtask

  task automatic test_no_clear();
    logic [AW-1:0] exp_addr;
    do_reset();
    clear_en = 1'b0;
    @(negedge clk);
    vsync = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'($urandom); req0_data = 4'($urandom);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b1 || clear_busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL noclear_grant[%0d]: got rdy=%0b busy=%0b want 1/0", i, req0_ready, clear_busy);
      end
      exp_addr = req0_addr;
      @(negedge clk);
      if (i == 0) vsync = 1'b1;
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== exp_addr) begin
        failures++;
        $display("[TB] FAIL noclear_write[%0d]: got en=%0b addr=%0h want 1/%0h", i, wr_en, wr_addr, exp_addr);
      end
      req0_addr = 8'($urandom);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int stray;
    do_reset();
    clear_en = 1'b1; clear_color = 4'd7;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1; clear_en = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int w = 0; w < 7; w++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(w)) begin
        failures++;
        $display("[TB] FAIL abort_write[%0d]: got en=%0b addr=%0d want 1/%0d", w, wr_en, wr_addr, w);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, clear_busy, clear_done, clear_overrun, req0_ready, req1_ready} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_reset: en=%0b addr=%0h data=%0h busy=%0b rdy=%0b%0b, all should be 0",
               wr_en, wr_addr, wr_data, clear_busy, req0_ready, req1_ready);
    end
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || clear_busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("[TB] FAIL abort_no_resume: got %0d cycles with writes or busy, want 0", stray);
    end
    req0_valid = 1'b1; req0_addr = 8'd9; req0_data = 4'd2;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_req0_ready: got %0b want 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 8'd9 || wr_data !== 4'd2) begin
      failures++;
      $display("[TB] FAIL abort_req0_write: got en=%0b addr=%0d data=%0d want 1/9/2", wr_en, wr_addr, wr_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin_after_reset();
    test_random_arbitration();
    test_clear_frame(1'b0);
    test_clear_frame(1'b1);
    test_no_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
